// File: rtl/ika9958_disp_pkg.sv
// ika9958_disp_pkg
// Shared constants and types for the display-position counter.
//   LAST_LINE_192 / LAST_LINE_212 : index of the last active line in each mode
//   H_ACTIVE_DEF                  : default number of active pixels per line
//   disp_flags_t                  : packed bundle of the status bits {f, fh, hr, vr}
//   last_line()                   : selects the last active line from the LN bit
package ika9958_disp_pkg;

    localparam logic [7:0] LAST_LINE_192 = 8'd191;
    localparam logic [7:0] LAST_LINE_212 = 8'd211;
    localparam int         H_ACTIVE_DEF  = 256;

    typedef struct packed {
        logic f;
        logic fh;
        logic hr;
        logic vr;
    } disp_flags_t;

    function automatic logic [7:0] last_line(input logic ln);
        return ln ? LAST_LINE_212 : LAST_LINE_192;
    endfunction

endpackage

// File: rtl/ika9958_disp_flag.sv
// ika9958_disp_flag
// Sticky status flag with set priority over clear.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high (flag -> 0)
//   ce  : clock enable; the flag only changes on enabled cycles
//   set : sets the flag
//   clr : clears the flag (ignored when set is also high)
//   q   : flag value
module ika9958_disp_flag
    import ika9958_disp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic set,
    input  logic clr,
    output logic q
);

    // A status read that lands in the same cycle as a new event must not
    // lose the event, so set is checked first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ce) begin
            if (set) begin
                q <= 1'b1;
            end else if (clr) begin
                q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ika9958_disp_cnt.sv
// ika9958_disp_cnt
// Display-position counter fed by the H/V-adjusted display-start ticks.
// Produces pixel X, scrolled line Y, active/border flags, retrace bits and
// the vertical / line interrupt request.
//   i_PHIA        : master clock, rising edge
//   i_RST         : asynchronous reset, active-high
//   i_PHIL_NCEN   : clock enable
//   i_HSTART      : first active pixel of every line
//   i_VSTART      : line preceding the first display line
//   i_LN          : 0 = 192 lines, 1 = 212 lines
//   i_R19, i_R23  : line-interrupt compare value, vertical scroll
//   i_IE0, i_IE1  : vertical / line interrupt enables
//   i_S0_RD/S1_RD : status register read strobes (clear F / FH)
//   o_X, o_Y      : pixel counter, scrolled display line
//   o_HACT/o_VACT : horizontal / vertical active, o_DISP = both
//   o_HR/o_VR     : retrace bits, o_F/o_FH : interrupt flags
//   o_INT_n       : registered interrupt request, active-low
// Optional: define IKA9958_DISPCNT_FRAMECNT_EN to add o_FRAMECNT[15:0],
// a wrapping count of completed frames.
module ika9958_disp_cnt
    import ika9958_disp_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int LINE_W   = 8
) (
    input  logic              i_PHIA,
    input  logic              i_RST,
    input  logic              i_PHIL_NCEN,
    input  logic              i_HSTART,
    input  logic              i_VSTART,
    input  logic              i_LN,
    input  logic [7:0]        i_R19,
    input  logic [7:0]        i_R23,
    input  logic              i_IE0,
    input  logic              i_IE1,
    input  logic              i_S0_RD,
    input  logic              i_S1_RD,
    output logic [8:0]        o_X,
    output logic [LINE_W-1:0] o_Y,
    output logic              o_HACT,
    output logic              o_VACT,
    output logic              o_DISP,
    output logic              o_HR,
    output logic              o_VR,
    output logic              o_F,
    output logic              o_FH,
    output logic              o_INT_n
`ifdef IKA9958_DISPCNT_FRAMECNT_EN
    ,
    output logic [15:0]       o_FRAMECNT
`endif
);

    localparam logic [8:0] X_LAST = 9'(H_ACTIVE - 1);
    localparam logic [8:0] X_HOLD = 9'(H_ACTIVE);

    logic [8:0]        x;
    logic              hact;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] line_next;
    logic              vact;
    logic              vact_next;
    logic              vpend;
    logic              int_n;
    logic              at_last;
    logic              frame_end;
    logic              fh_set;
    logic              f;
    logic              fh;
    disp_flags_t       flags;

    // LN is sampled live, so a mode switch mid-frame ends the frame at the
    // next line start once the counter is already past the new last line.
    assign at_last   = (line >= LINE_W'(last_line(i_LN)));
    assign frame_end = i_HSTART & ~vpend & vact & at_last;

    // A pending vertical start outranks normal line advance, which is what
    // lets a mid-frame VSTART restart the frame without raising F.
    always_comb begin
        line_next = line;
        vact_next = vact;
        if (i_HSTART) begin
            if (vpend) begin
                line_next = '0;
                vact_next = 1'b1;
            end else if (vact) begin
                if (at_last) begin
                    vact_next = 1'b0;
                end else begin
                    line_next = line + LINE_W'(1);
                end
            end
        end
    end

    // The line interrupt compares against the Y that the new line will show.
    assign fh_set = i_HSTART & vact_next &
                    ((line_next + LINE_W'(i_R23)) == LINE_W'(i_R19));

    // VSTART coinciding with HSTART only arms vpend for the following line,
    // because vpend is cleared by HSTART only when VSTART is low.
    always_ff @(posedge i_PHIA or posedge i_RST) begin
        if (i_RST) begin
            x     <= '0;
            hact  <= 1'b0;
            line  <= '0;
            vact  <= 1'b0;
            vpend <= 1'b0;
            int_n <= 1'b1;
        end else if (i_PHIL_NCEN) begin
            if (i_HSTART) begin
                x    <= '0;
                hact <= 1'b1;
            end else if (hact) begin
                if (x == X_LAST) begin
                    x    <= X_HOLD;
                    hact <= 1'b0;
                end else begin
                    x <= x + 9'd1;
                end
            end
            line  <= line_next;
            vact  <= vact_next;
            vpend <= i_VSTART | (vpend & ~i_HSTART);
            int_n <= ~((f & i_IE0) | (fh & i_IE1));
        end
    end

    ika9958_disp_flag u_flag_f (
        .clk (i_PHIA),
        .rst (i_RST),
        .ce  (i_PHIL_NCEN),
        .set (frame_end),
        .clr (i_S0_RD),
        .q   (f)
    );

    ika9958_disp_flag u_flag_fh (
        .clk (i_PHIA),
        .rst (i_RST),
        .ce  (i_PHIL_NCEN),
        .set (fh_set),
        .clr (i_S1_RD),
        .q   (fh)
    );

`ifdef IKA9958_DISPCNT_FRAMECNT_EN
    logic [15:0] framecnt;

    // Counts exactly the events that raise F at frame end.
    always_ff @(posedge i_PHIA or posedge i_RST) begin
        if (i_RST) begin
            framecnt <= '0;
        end else if (i_PHIL_NCEN && frame_end) begin
            framecnt <= framecnt + 16'd1;
        end
    end

    assign o_FRAMECNT = framecnt;
`endif

    assign flags.f  = f;
    assign flags.fh = fh;
    assign flags.hr = ~hact;
    assign flags.vr = ~vact;

    assign o_X     = x;
    assign o_Y     = line + LINE_W'(i_R23);
    assign o_HACT  = hact;
    assign o_VACT  = vact;
    assign o_DISP  = hact & vact;
    assign o_HR    = flags.hr;
    assign o_VR    = flags.vr;
    assign o_F     = flags.f;
    assign o_FH    = flags.fh;
    assign o_INT_n = int_n;

endmodule

// File: tb/tb_ika9958_disp_cnt.sv
// tb_ika9958_disp_cnt
// Self-checking bench for ika9958_disp_cnt. Expected X / Y values are pushed
// to queues as each stimulus is driven and popped once the DUT has updated.
// Define IKA9958_DISPCNT_FRAMECNT_EN to also check the frame counter.
module tb_ika9958_disp_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic       hstart = 1'b0;
    logic       vstart = 1'b0;
    logic       ln = 1'b0;
    logic [7:0] r19 = 8'd255;
    logic [7:0] r23 = 8'd0;
    logic       ie0 = 1'b0;
    logic       ie1 = 1'b0;
    logic       s0_rd = 1'b0;
    logic       s1_rd = 1'b0;

    logic [8:0] o_x;
    logic [7:0] o_y;
    logic       o_hact, o_vact, o_disp, o_hr, o_vr, o_f, o_fh, o_int_n;
`ifdef IKA9958_DISPCNT_FRAMECNT_EN
    logic [15:0] o_framecnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] exp_x_q[$];
    logic [7:0] exp_y_q[$];

    ika9958_disp_cnt dut (
        .i_PHIA      (clk),
        .i_RST       (rst),
        .i_PHIL_NCEN (ce),
        .i_HSTART    (hstart),
        .i_VSTART    (vstart),
        .i_LN        (ln),
        .i_R19       (r19),
        .i_R23       (r23),
        .i_IE0       (ie0),
        .i_IE1       (ie1),
        .i_S0_RD     (s0_rd),
        .i_S1_RD     (s1_rd),
        .o_X         (o_x),
        .o_Y         (o_y),
        .o_HACT      (o_hact),
        .o_VACT      (o_vact),
        .o_DISP      (o_disp),
        .o_HR        (o_hr),
        .o_VR        (o_vr),
        .o_F         (o_f),
        .o_FH        (o_fh),
        .o_INT_n     (o_int_n)
`ifdef IKA9958_DISPCNT_FRAMECNT_EN
        ,
        .o_FRAMECNT  (o_framecnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one HSTART tick and queues the Y the new line should show.
    task automatic line_start(input logic [7:0] exp_y);
        exp_y_q.push_back(exp_y);
        hstart = 1'b1;
        tick();
        hstart = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1;
        idle(2);
        got = {o_hact, o_vact, o_disp, o_hr, o_vr, o_f, o_fh, o_int_n, 2'b00};
        tests_run++;
        if (got !== 10'b00_0110_0100) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0001100100", got);
        end
        tests_run++;
        if (o_x !== 9'd0 || o_y !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", o_x, o_y);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_horizontal();
        logic [8:0] ex;
        logic       eh;
        int         hact_cnt;
        hact_cnt = 0;
        for (int i = 0; i < 342; i++) begin
            hstart = (i == 0);
            exp_x_q.push_back(i < 256 ? 9'(i) : 9'd256);
            tick();
            hstart = 1'b0;
            ex = exp_x_q.pop_front();
            eh = (i < 256);
            if (o_hact) hact_cnt++;
            tests_run++;
            if (o_x !== ex || o_hact !== eh || o_hr !== ~eh) begin
                tests_failed++;
                $display("FAIL hsweep_%0d: got x=%0d hact=%b hr=%b want x=%0d hact=%b", i, o_x, o_hact, o_hr, ex, eh);
            end
        end
        tests_run++;
        if (hact_cnt !== 256) begin
            tests_failed++;
            $display("FAIL hact_width: got %0d want 256", hact_cnt);
        end
        tests_run++;
        if (o_vact !== 1'b0 || o_int_n !== 1'b1 || o_disp !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_vstart: got vact=%b int_n=%b disp=%b want 0 1 0", o_vact, o_int_n, o_disp);
        end
        // Clock enable gating: X must freeze and HSTART must be ignored.
        hstart = 1'b1;
        tick();
        hstart = 1'b0;
        idle(5);
        ce = 1'b0;
        idle(2);
        hstart = 1'b1;
        tick();
        hstart = 1'b0;
        idle(2);
        tests_run++;
        if (o_x !== 9'd5) begin
            tests_failed++;
            $display("FAIL ce_hold: got x=%0d want 5", o_x);
        end
        ce = 1'b1;
        tick();
        tests_run++;
        if (o_x !== 9'd6) begin
            tests_failed++;
            $display("FAIL ce_resume: got x=%0d want 6", o_x);
        end
    endtask

    task automatic test_frame_192();
        logic [7:0] ey;
        ie0 = 1'b1;
        ln = 1'b0;
        r23 = 8'd0;
        r19 = 8'd255;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        for (int n = 0; n < 192; n++) begin
            line_start(8'(n));
            ey = exp_y_q.pop_front();
            tests_run++;
            if (o_vact !== 1'b1 || o_y !== ey || o_f !== 1'b0) begin
                tests_failed++;
                $display("FAIL f192_line%0d: got vact=%b y=%0d f=%b want 1 %0d 0", n, o_vact, o_y, o_f, ey);
            end
            idle(7);
        end
        line_start(8'd191);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b0 || o_f !== 1'b1 || o_int_n !== 1'b1 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL f192_end: got vact=%b f=%b int_n=%b y=%0d want 0 1 1 %0d", o_vact, o_f, o_int_n, o_y, ey);
        end
        tick();
        tests_run++;
        if (o_int_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL f192_int_low: got int_n=%b want 0", o_int_n);
        end
        s0_rd = 1'b1;
        tick();
        s0_rd = 1'b0;
        tests_run++;
        if (o_f !== 1'b0 || o_int_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL f192_clear: got f=%b int_n=%b want 0 0", o_f, o_int_n);
        end
        tick();
        tests_run++;
        if (o_int_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL f192_int_high: got int_n=%b want 1", o_int_n);
        end
        idle(3);
        line_start(8'd191);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b0 || o_y !== ey || o_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL f192_hold: got vact=%b y=%0d f=%b want 0 %0d 0", o_vact, o_y, o_f, ey);
        end
        ie0 = 1'b0;
        idle(4);
    endtask

    task automatic test_line_irq();
        logic [7:0] ey;
        r23 = 8'd250;
        r19 = 8'd4;
        ie1 = 1'b1;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        for (int n = 0; n <= 10; n++) begin
            line_start(8'(n) + 8'd250);
            ey = exp_y_q.pop_front();
            tests_run++;
            if (o_vact !== 1'b1 || o_y !== ey || o_fh !== (n == 10)) begin
                tests_failed++;
                $display("FAIL lirq_line%0d: got vact=%b y=%0d fh=%b want 1 %0d %b", n, o_vact, o_y, o_fh, ey, (n == 10));
            end
            if (n < 10) idle(7);
        end
        tick();
        tests_run++;
        if (o_int_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL lirq_int_low: got int_n=%b want 0", o_int_n);
        end
        s1_rd = 1'b1;
        tick();
        s1_rd = 1'b0;
        tests_run++;
        if (o_fh !== 1'b0) begin
            tests_failed++;
            $display("FAIL lirq_clear: got fh=%b want 0", o_fh);
        end
        tick();
        tests_run++;
        if (o_int_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL lirq_int_high: got int_n=%b want 1", o_int_n);
        end
        idle(3);
        // Line 11 shows Y=5; matching it while reading S#1 must keep FH set.
        r19 = 8'd5;
        s1_rd = 1'b1;
        line_start(8'd5);
        s1_rd = 1'b0;
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_fh !== 1'b1 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL lirq_set_wins: got fh=%b y=%0d want 1 %0d", o_fh, o_y, ey);
        end
        r19 = 8'd200;
        idle(7);
        for (int n = 12; n < 192; n++) begin
            line_start(8'(n) + 8'd250);
            ey = exp_y_q.pop_front();
            tests_run++;
            if (o_vact !== 1'b1 || o_y !== ey) begin
                tests_failed++;
                $display("FAIL lirq_line%0d: got vact=%b y=%0d want 1 %0d", n, o_vact, o_y, ey);
            end
            idle(7);
        end
        s0_rd = 1'b1;
        line_start(8'd185);
        s0_rd = 1'b0;
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_f !== 1'b1 || o_vact !== 1'b0 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL lirq_f_set_wins: got f=%b vact=%b y=%0d want 1 0 %0d", o_f, o_vact, o_y, ey);
        end
        ie1 = 1'b0;
        idle(4);
    endtask

    task automatic test_ln_switch();
        logic [7:0] ey;
        s0_rd = 1'b1;
        s1_rd = 1'b1;
        tick();
        s0_rd = 1'b0;
        s1_rd = 1'b0;
        r23 = 8'd0;
        r19 = 8'd255;
        ln = 1'b1;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        for (int n = 0; n <= 200; n++) begin
            line_start(8'(n));
            ey = exp_y_q.pop_front();
            tests_run++;
            if (o_vact !== 1'b1 || o_y !== ey || o_f !== 1'b0) begin
                tests_failed++;
                $display("FAIL ln212_line%0d: got vact=%b y=%0d f=%b want 1 %0d 0", n, o_vact, o_y, o_f, ey);
            end
            idle(7);
        end
        ln = 1'b0;
        line_start(8'd200);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b0 || o_f !== 1'b1 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL ln_switch_end: got vact=%b f=%b y=%0d want 0 1 %0d", o_vact, o_f, o_y, ey);
        end
        s0_rd = 1'b1;
        tick();
        s0_rd = 1'b0;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        for (int n = 0; n <= 10; n++) begin
            line_start(8'(n));
            ey = exp_y_q.pop_front();
            tests_run++;
            if (o_vact !== 1'b1 || o_y !== ey) begin
                tests_failed++;
                $display("FAIL restart_line%0d: got vact=%b y=%0d want 1 %0d", n, o_vact, o_y, ey);
            end
            idle(7);
        end
        // VSTART mid-frame: next line restarts at 0 and F stays clear.
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        line_start(8'd0);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b1 || o_y !== ey || o_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_vstart: got vact=%b y=%0d f=%b want 1 %0d 0", o_vact, o_y, o_f, ey);
        end
        idle(7);
        for (int n = 1; n <= 3; n++) begin
            line_start(8'(n));
            void'(exp_y_q.pop_front());
            idle(7);
        end
        // VSTART together with HSTART: this line still advances, next restarts.
        vstart = 1'b1;
        line_start(8'd4);
        vstart = 1'b0;
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b1 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL same_cycle_v_h: got vact=%b y=%0d want 1 %0d", o_vact, o_y, ey);
        end
        idle(7);
        line_start(8'd0);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_vact !== 1'b1 || o_y !== ey || o_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_restart: got vact=%b y=%0d f=%b want 1 %0d 0", o_vact, o_y, o_f, ey);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ey;
        r23 = 8'd0;
        r19 = 8'd50;
        ie1 = 1'b1;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        idle(3);
        for (int n = 0; n <= 50; n++) begin
            line_start(8'(n));
            ey = exp_y_q.pop_front();
            if (n < 50) idle(7);
        end
        idle(100);
        tests_run++;
        if (o_x !== 9'd100 || o_y !== ey || o_disp !== 1'b1 || o_fh !== 1'b1 || o_int_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset: got x=%0d y=%0d disp=%b fh=%b int_n=%b want 100 %0d 1 1 0", o_x, o_y, o_disp, o_fh, o_int_n, ey);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (o_x !== 9'd0 || o_y !== 8'd0 || o_hact !== 1'b0 || o_vact !== 1'b0 || o_hr !== 1'b1 ||
            o_vr !== 1'b1 || o_f !== 1'b0 || o_fh !== 1'b0 || o_int_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: got x=%0d y=%0d hact=%b vact=%b hr=%b vr=%b f=%b fh=%b int_n=%b want 0 0 0 0 1 1 0 0 1",
                     o_x, o_y, o_hact, o_vact, o_hr, o_vr, o_f, o_fh, o_int_n);
        end
        idle(2);
        rst = 1'b0;
        ie1 = 1'b0;
        r19 = 8'd255;
        idle(5);
        tests_run++;
        if (o_x !== 9'd0 || o_hact !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got x=%0d hact=%b want 0 0", o_x, o_hact);
        end
        line_start(8'd0);
        ey = exp_y_q.pop_front();
        tests_run++;
        if (o_x !== 9'd0 || o_hact !== 1'b1 || o_vact !== 1'b0 || o_y !== ey) begin
            tests_failed++;
            $display("FAIL post_reset_resume: got x=%0d hact=%b vact=%b y=%0d want 0 1 0 %0d", o_x, o_hact, o_vact, o_y, ey);
        end
        idle(7);
`ifdef IKA9958_DISPCNT_FRAMECNT_EN
        tests_run++;
        if (o_framecnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL framecnt_reset: got %0d want 0", o_framecnt);
        end
        ln = 1'b0;
        for (int fr = 0; fr < 3; fr++) begin
            vstart = 1'b1;
            tick();
            vstart = 1'b0;
            idle(3);
            for (int n = 0; n <= 192; n++) begin
                line_start(8'(n));
                void'(exp_y_q.pop_front());
                idle(7);
            end
        end
        tests_run++;
        if (o_framecnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL framecnt_3: got %0d want 3", o_framecnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_frame_192();
        test_line_irq();
        test_ln_switch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
